// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared widths, write-back encodings and ID/EX register layout for miniRV-1.
package pipeline_pkg;
  localparam int XLEN = 32;
  localparam int ALUOP_W = 4;
  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_LOAD = 2'b01;
  localparam logic [1:0] WD_PC4 = 2'b10;
  localparam logic [1:0] WD_IMM = 2'b11;
  typedef struct packed {
    logic valid;
    logic rf_we;
    logic ram_we;
    logic [1:0] wd_sel;
    logic [ALUOP_W-1:0] alu_op;
    logic alub_sel;
  } ctrl_t;
  localparam ctrl_t BUBBLE = '0;
  typedef struct packed {
    ctrl_t ctrl;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [4:0] rr1;
    logic [4:0] rr2;
    logic [4:0] rd;
  } ex_t;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: load-use detection between the load in EX and the instruction in ID.
module hazard_detect
  import pipeline_pkg::*;
(
  input  logic       ex_valid,
  input  logic       ex_rf_we,
  input  logic [1:0] ex_wd_sel,
  input  logic [4:0] ex_rd,
  input  logic       id_valid,
  input  logic       id_use1,
  input  logic       id_use2,
  input  logic [4:0] id_rr1,
  input  logic [4:0] id_rr2,
  input  logic       flush,
  output logic       lu,
  output logic       stall
);
  logic dep;
  assign dep = (id_use1 && id_rr1 == ex_rd) || (id_use2 && id_rr2 == ex_rd);
  assign lu = ex_valid && ex_rf_we && ex_wd_sel == WD_LOAD && ex_rd != 5'd0 && id_valid && dep;
  // a flushed dependent instruction is dead, so it must not hold the front end
  assign stall = lu && !flush;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with capture/output bypass and load-use bubble insertion.
module id_ex_stage
  import pipeline_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [XLEN-1:0]    id_pc,
  input  logic [XLEN-1:0]    id_imm,
  input  logic [4:0]         id_rr1,
  input  logic [4:0]         id_rr2,
  input  logic               id_use1,
  input  logic               id_use2,
  input  logic [4:0]         id_rd,
  input  logic               id_rf_we,
  input  logic [1:0]         id_wd_sel,
  input  logic [ALUOP_W-1:0] id_alu_op,
  input  logic               id_alub_sel,
  input  logic               id_ram_we,
  input  logic [XLEN-1:0]    rf_rd1,
  input  logic [XLEN-1:0]    rf_rd2,
  input  logic               rd1_i_sel,
  input  logic               rd2_i_sel,
  input  logic [XLEN-1:0]    fwd_rd1_i,
  input  logic [XLEN-1:0]    fwd_rd2_i,
  input  logic               rd1_o_sel,
  input  logic               rd2_o_sel,
  input  logic [XLEN-1:0]    fwd_rd1_o,
  input  logic [XLEN-1:0]    fwd_rd2_o,
  input  logic               flush,
  output logic               ex_valid,
  output logic [XLEN-1:0]    ex_pc,
  output logic [XLEN-1:0]    ex_imm,
  output logic [4:0]         ex_rr1,
  output logic [4:0]         ex_rr2,
  output logic [4:0]         ex_rd,
  output logic               ex_rf_we,
  output logic               ex_ram_we,
  output logic [1:0]         ex_wd_sel,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic               ex_alub_sel,
  output logic [XLEN-1:0]    ex_rd1,
  output logic [XLEN-1:0]    ex_rd2,
  output logic               stall_o
);
  ex_t q, nxt;
  logic lu;
  hazard_detect u_hd (
    .ex_valid (q.ctrl.valid),
    .ex_rf_we (q.ctrl.rf_we),
    .ex_wd_sel(q.ctrl.wd_sel),
    .ex_rd    (q.rd),
    .id_valid (id_valid),
    .id_use1  (id_use1),
    .id_use2  (id_use2),
    .id_rr1   (id_rr1),
    .id_rr2   (id_rr2),
    .flush    (flush),
    .lu       (lu),
    .stall    (stall_o)
  );
  always_comb begin
    nxt.ctrl.valid = id_valid;
    nxt.ctrl.rf_we = id_rf_we && id_valid;
    nxt.ctrl.ram_we = id_ram_we && id_valid;
    nxt.ctrl.wd_sel = id_wd_sel;
    nxt.ctrl.alu_op = id_alu_op;
    nxt.ctrl.alub_sel = id_alub_sel;
    nxt.pc = id_pc;
    nxt.imm = id_imm;
    nxt.rd1 = rd1_i_sel ? fwd_rd1_i : rf_rd1;
    nxt.rd2 = rd2_i_sel ? fwd_rd2_i : rf_rd2;
    nxt.rr1 = id_rr1;
    nxt.rr2 = id_rr2;
    nxt.rd = id_rd;
    if (flush || lu) begin
      nxt = '0;
      nxt.ctrl = BUBBLE;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else q <= nxt;
  assign ex_valid = q.ctrl.valid;
  assign ex_rf_we = q.ctrl.rf_we;
  assign ex_ram_we = q.ctrl.ram_we;
  assign ex_wd_sel = q.ctrl.wd_sel;
  assign ex_alu_op = q.ctrl.alu_op;
  assign ex_alub_sel = q.ctrl.alub_sel;
  assign ex_pc = q.pc;
  assign ex_imm = q.imm;
  assign ex_rr1 = q.rr1;
  assign ex_rr2 = q.rr2;
  assign ex_rd = q.rd;
  assign ex_rd1 = rd1_o_sel ? fwd_rd1_o : q.rd1;
  assign ex_rd2 = rd2_o_sel ? fwd_rd2_o : q.rd2;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed scoreboard bench for the ID/EX register, bypass muxes and load-use bubble.
module tb_id_ex_stage;
  logic clk = 0, rst = 1;
  logic id_valid = 0, id_use1 = 0, id_use2 = 0, id_rf_we = 0, id_alub_sel = 0, id_ram_we = 0;
  logic [31:0] id_pc = 0, id_imm = 0, rf_rd1 = 0, rf_rd2 = 0, fwd_rd1_i = 0, fwd_rd2_i = 0, fwd_rd1_o = 0, fwd_rd2_o = 0;
  logic [4:0] id_rr1 = 0, id_rr2 = 0, id_rd = 0;
  logic [1:0] id_wd_sel = 0;
  logic [3:0] id_alu_op = 0;
  logic rd1_i_sel = 0, rd2_i_sel = 0, rd1_o_sel = 0, rd2_o_sel = 0, flush = 0;
  logic ex_valid, ex_rf_we, ex_ram_we, ex_alub_sel, stall_o;
  logic [31:0] ex_pc, ex_imm, ex_rd1, ex_rd2;
  logic [4:0] ex_rr1, ex_rr2, ex_rd;
  logic [1:0] ex_wd_sel;
  logic [3:0] ex_alu_op;
  int total = 0, bad = 0;

  typedef struct {
    logic v, rf_we, ram_we, bs;
    logic [31:0] pc, imm, rd1, rd2;
    logic [4:0] rr1, rr2, rd;
    logic [1:0] wd;
    logic [3:0] op;
  } exp_t;
  exp_t sb[$];
  exp_t cur = '{default: 0};

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_imm(id_imm),
    .id_rr1(id_rr1), .id_rr2(id_rr2), .id_use1(id_use1), .id_use2(id_use2), .id_rd(id_rd),
    .id_rf_we(id_rf_we), .id_wd_sel(id_wd_sel), .id_alu_op(id_alu_op), .id_alub_sel(id_alub_sel),
    .id_ram_we(id_ram_we), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .rd1_i_sel(rd1_i_sel), .rd2_i_sel(rd2_i_sel),
    .fwd_rd1_i(fwd_rd1_i), .fwd_rd2_i(fwd_rd2_i), .rd1_o_sel(rd1_o_sel), .rd2_o_sel(rd2_o_sel),
    .fwd_rd1_o(fwd_rd1_o), .fwd_rd2_o(fwd_rd2_o), .flush(flush), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_imm(ex_imm), .ex_rr1(ex_rr1), .ex_rr2(ex_rr2), .ex_rd(ex_rd), .ex_rf_we(ex_rf_we),
    .ex_ram_we(ex_ram_we), .ex_wd_sel(ex_wd_sel), .ex_alu_op(ex_alu_op), .ex_alub_sel(ex_alub_sel),
    .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .stall_o(stall_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_ex(input exp_t e);
    chk("ex_valid", 32'(ex_valid), 32'(e.v));
    chk("ex_rf_we", 32'(ex_rf_we), 32'(e.rf_we));
    chk("ex_ram_we", 32'(ex_ram_we), 32'(e.ram_we));
    chk("ex_alub_sel", 32'(ex_alub_sel), 32'(e.bs));
    chk("ex_pc", ex_pc, e.pc);
    chk("ex_imm", ex_imm, e.imm);
    chk("ex_rd1", ex_rd1, e.rd1);
    chk("ex_rd2", ex_rd2, e.rd2);
    chk("ex_rr1", 32'(ex_rr1), 32'(e.rr1));
    chk("ex_rr2", 32'(ex_rr2), 32'(e.rr2));
    chk("ex_rd", 32'(ex_rd), 32'(e.rd));
    chk("ex_wd_sel", 32'(ex_wd_sel), 32'(e.wd));
    chk("ex_alu_op", 32'(ex_alu_op), 32'(e.op));
  endtask

  // Inputs are already driven; checks stall before the edge, predicts EX contents, clocks, then scores.
  task automatic step(input string tag);
    logic lu;
    exp_t e;
    #1;
    lu = cur.v && cur.rf_we && cur.wd == 2'b01 && cur.rd != 0 && id_valid &&
         ((id_use1 && id_rr1 == cur.rd) || (id_use2 && id_rr2 == cur.rd));
    chk({tag, ":stall"}, 32'(stall_o), 32'(lu && !flush));
    e = '{default: 0};
    if (!(flush || lu)) begin
      e.v = id_valid; e.rf_we = id_rf_we && id_valid; e.ram_we = id_ram_we && id_valid;
      e.bs = id_alub_sel; e.pc = id_pc; e.imm = id_imm; e.rr1 = id_rr1; e.rr2 = id_rr2;
      e.rd = id_rd; e.wd = id_wd_sel; e.op = id_alu_op;
      e.rd1 = rd1_i_sel ? fwd_rd1_i : rf_rd1;
      e.rd2 = rd2_i_sel ? fwd_rd2_i : rf_rd2;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++; bad++;
      $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
    end else begin
      e = sb.pop_front();
      cur = e;
      chk_ex(e);
    end
  endtask

  task automatic instr(input logic v, input logic [31:0] pc, input logic [4:0] rd, input logic [1:0] wd,
                       input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2);
    id_valid = v; id_pc = pc; id_rd = rd; id_wd_sel = wd; id_rf_we = 1; id_ram_we = 0;
    id_rr1 = r1; id_use1 = u1; id_rr2 = r2; id_use2 = u2;
    id_imm = pc ^ 32'h0000_0F0F; id_alu_op = pc[5:2]; id_alub_sel = pc[2];
    rf_rd1 = pc + 32'd1; rf_rd2 = pc + 32'd2;
  endtask

  initial begin
    #3;
    chk_ex('{default: 0});
    chk("reset:stall", 32'(stall_o), 0);
    @(posedge clk); #1;
    rst = 0;
    // plain capture
    instr(1, 32'h100, 5'd3, 2'b00, 5'd1, 1, 5'd2, 1);
    rf_rd1 = 32'd5;
    step("plain");
    // capture-side bypass, then output-side bypass in the same cycle
    instr(1, 32'h104, 5'd4, 2'b00, 5'd3, 1, 5'd2, 0);
    rf_rd1 = 0; rd1_i_sel = 1; fwd_rd1_i = 32'hDEAD;
    rd2_i_sel = 1; fwd_rd2_i = 32'h1234;
    step("wb_bypass");
    rd1_i_sel = 0; rd2_i_sel = 0;
    rd1_o_sel = 1; fwd_rd1_o = 32'hBEEF; rd2_o_sel = 1; fwd_rd2_o = 32'hCAFE;
    #1;
    chk("out_bypass1", ex_rd1, 32'hBEEF);
    chk("out_bypass2", ex_rd2, 32'hCAFE);
    rd1_o_sel = 0; rd2_o_sel = 0;
    #1;
    chk("out_nobypass1", ex_rd1, 32'hDEAD);
    // load-use: lw x5 then add reading x5
    instr(1, 32'h108, 5'd5, 2'b01, 5'd1, 1, 5'd0, 0);
    step("lw_x5");
    instr(1, 32'h10C, 5'd6, 2'b00, 5'd5, 1, 5'd7, 1);
    step("lu_bubble");
    step("lu_replay");
    // lw x0 never hazards
    instr(1, 32'h110, 5'd0, 2'b01, 5'd1, 1, 5'd0, 0);
    step("lw_x0");
    instr(1, 32'h114, 5'd8, 2'b00, 5'd0, 1, 5'd0, 1);
    step("use_x0");
    // operand index matches but is not used
    instr(1, 32'h118, 5'd5, 2'b01, 5'd1, 1, 5'd0, 0);
    step("lw_x5b");
    instr(1, 32'h11C, 5'd9, 2'b00, 5'd5, 0, 5'd5, 0);
    step("no_use");
    // hazard on operand 2 killed by flush
    instr(1, 32'h120, 5'd5, 2'b01, 5'd1, 1, 5'd0, 0);
    step("lw_x5c");
    instr(1, 32'h124, 5'd10, 2'b00, 5'd1, 1, 5'd5, 1);
    flush = 1;
    step("flush_lu");
    flush = 0;
    // invalid store is gated, valid store passes
    instr(0, 32'h128, 5'd0, 2'b00, 5'd1, 1, 5'd2, 1);
    id_ram_we = 1;
    step("inv_store");
    instr(1, 32'h12C, 5'd0, 2'b00, 5'd1, 1, 5'd2, 1);
    id_ram_we = 1; id_rf_we = 0;
    step("store");
    // load-use pending, then async reset between edges
    instr(1, 32'h130, 5'd5, 2'b01, 5'd1, 1, 5'd0, 0);
    step("lw_x5d");
    instr(1, 32'h134, 5'd11, 2'b00, 5'd5, 1, 5'd0, 0);
    #1;
    chk("pre_rst:stall", 32'(stall_o), 1);
    chk("pre_rst:valid", 32'(ex_valid), 1);
    rst = 1;
    #1;
    chk_ex('{default: 0});
    chk("rst:stall", 32'(stall_o), 0);
    cur = '{default: 0};
    @(posedge clk); #1;
    rst = 0;
    step("post_rst");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the miniRV-1 five-stage pipeline. Sits between decode/register-file read and execute.
- Captures decoded control, PC, immediate and register-file operands each cycle.
- Applies the write-back bypass on capture and the EX/MEM and MEM/WB bypass on output, using the select/data signals produced by the forwarding unit.
- Detects load-use hazards: inserts one bubble and stalls IF/ID for one cycle.

Parameters:
- XLEN, 32, datapath width.
- ALUOP_W, 4, ALU opcode width.
- WD_LOAD, 2'b01, wd_sel encoding meaning "write-back data comes from data RAM".

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_pc  in  XLEN  PC of the ID instruction.
- id_imm  in  XLEN  sign-extended immediate.
- id_rr1, id_rr2  in  5  source register indices.
- id_use1, id_use2  in  1  instruction actually reads rr1/rr2.
- id_rd  in  5  destination register.
- id_rf_we  in  1  register-file write enable.
- id_wd_sel  in  2  write-back source select.
- id_alu_op  in  ALUOP_W  ALU operation.
- id_alub_sel  in  1  ALU B operand: 0 = rd2, 1 = imm.
- id_ram_we  in  1  data-RAM write enable.
- rf_rd1, rf_rd2  in  XLEN  raw register-file read data.
- rd1_i_sel, rd2_i_sel  in  1  capture-side bypass select.
- fwd_rd1_i, fwd_rd2_i  in  XLEN  capture-side bypass data.
- rd1_o_sel, rd2_o_sel  in  1  output-side bypass select.
- fwd_rd1_o, fwd_rd2_o  in  XLEN  output-side bypass data.
- flush  in  1  taken branch/jump resolved in EX; kill the ID instruction.
- ex_valid  out  1  EX holds a real instruction.
- ex_pc, ex_imm  out  XLEN  registered PC and immediate.
- ex_rr1, ex_rr2  out  5  registered source indices (to forwarding unit).
- ex_rd  out  5  registered destination.
- ex_rf_we, ex_ram_we  out  1  registered write enables, gated by ex_valid.
- ex_wd_sel  out  2  registered write-back select.
- ex_alu_op  out  ALUOP_W  registered ALU operation.
- ex_alub_sel  out  1  registered ALU B select.
- ex_rd1, ex_rd2  out  XLEN  forwarded operands for EX.
- stall_o  out  1  hold PC and IF/ID this cycle.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset: every register clears to 0. Therefore ex_valid=0, ex_rf_we=0, ex_ram_we=0, all data fields 0, and stall_o=0. Reset mid-stall clears the hazard and stall_o drops the same cycle reset asserts.
- Capture mux (combinational):
  - cap1 = rd1_i_sel ? fwd_rd1_i : rf_rd1.
  - cap2 likewise for operand 2.
- Hazard detection (combinational on registered EX state):
  - lu = ex_valid & ex_rf_we & (ex_wd_sel==WD_LOAD) & (ex_rd!=0) & id_valid & ((id_use1 & id_rr1==ex_rd) | (id_use2 & id_rr2==ex_rd)).
  - stall_o = lu & ~flush.
- Register update each rising edge, in priority order:
  - flush=1: load a bubble (ex_valid=0, rf_we=0, ram_we=0, other fields don't-care but driven 0).
  - else lu=1: load a bubble. The ID instruction is held upstream by stall_o and re-presented next cycle.
  - else: capture all id_* fields and cap1/cap2. ex_valid=id_valid; write enables are ANDed with id_valid.
- Output mux (combinational):
  - ex_rd1 = rd1_o_sel ? fwd_rd1_o : registered rd1.
  - ex_rd2 likewise.
- Latency: one cycle ID to EX. A bubble costs exactly one cycle. stall_o is never asserted two consecutive cycles for the same instruction, because the bubble clears ex_valid.
- Simultaneous flush and lu: flush wins and stall_o=0, since the dependent instruction is dead.
- rd=0 destination never triggers a hazard.
- All arithmetic is none; fields are passed at full width.

Decomposition:
- Shared package (pipeline_pkg): XLEN, ALUOP_W, wd_sel encodings (WD_ALU, WD_LOAD, WD_PC4, WD_IMM), and a bubble control constant.
- Sub-module hazard_detect: combinational lu/stall_o logic, kept separate for reuse by a future IF/ID stage.
- The pipeline register and bypass muxes stay in the top module.

Test Plan:
- Plain capture: id_valid=1, id_pc=0x100, rf_rd1=5, rd1_i_sel=0, rd1_o_sel=0 -> next cycle ex_pc=0x100, ex_rd1=5, ex_valid=1, stall_o=0 throughout.
- Write-back bypass on capture: rf_rd1=0, rd1_i_sel=1, fwd_rd1_i=0xDEAD -> ex_rd1=0xDEAD next cycle. Then rd1_o_sel=1, fwd_rd1_o=0xBEEF -> ex_rd1=0xBEEF in the same cycle.
- Load-use: EX holds lw x5 (wd_sel=01, rd=5, rf_we=1); ID presents add reading x5 with id_use1=1 -> stall_o=1 for one cycle. Next cycle ex_valid=0 and ex_rf_we=0. The following cycle the add is captured and stall_o=0.
- No false hazard: EX holds lw x0, or ID reads x5 with id_use1=id_use2=0 -> stall_o=0, instruction captured normally.
- Flush priority: load-use condition plus flush=1 -> stall_o=0 and a bubble is loaded (ex_valid=0).
- Async reset: assert rst between edges while ex_valid=1 and stall_o=1 -> all outputs 0 immediately, before the next clk edge.
